request_unit: RTL
=================

# request_unit

Memory-request sequencer between the control unit and the instruction/data cache ports of the single-cycle MIPS datapath. It takes the control unit's decoded `iREN`/`dREN`/`dWEN`/`halt` and sequences the cache requests one at a time. Instruction fetch stalls while a load/store is outstanding. It also produces the PC-advance enable and the latched halt indication. Two saturating performance counters (retired instructions, stall cycles) are kept for the testbench and system dump.

## Interface
Parameters:
- `CW`, 32, width of each performance counter.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `nRST`  in  1  reset, synchronous, active-low.
- `iREN`  in  1  instruction-read request from the control unit.
- `dREN`  in  1  data-read request from the control unit (load).
- `dWEN`  in  1  data-write request from the control unit (store).
- `halt`  in  1  halt decoded by the control unit.
- `ihit`  in  1  instruction cache returns a valid word this cycle.
- `dhit`  in  1  data cache completes the read/write this cycle.
- `imemREN`  out  1  instruction read request to the cache.
- `dmemREN`  out  1  data read request to the cache.
- `dmemWEN`  out  1  data write request to the cache.
- `pc_en`  out  1  PC and register file commit enable for this cycle.
- `halted`  out  1  processor halted, sticky until reset.
- `instr_count`  out  CW  instructions retired.
- `stall_count`  out  CW  cycles spent waiting on `ihit` or `dhit`.

## Operation
The state machine has three states: FETCH, DATA and HALT.

Registers:
- `state`
- `rd_q` and `wr_q`: latched data request.
- Two counters.

**FETCH**
- `imemREN = iREN`; `dmemREN = dmemWEN = 0`.
- On `ihit & halt`:
  - Next state is HALT; `pc_en = 0`.
  - `halt` takes priority over any `dREN`/`dWEN` in the same cycle.
- On `ihit & ~halt & (dREN | dWEN)`:
  - Next state is DATA; `pc_en = 0`.
  - Latch `wr_q = dWEN` and `rd_q = dREN & ~dWEN`. A write wins if both are asserted.
- On `ihit & ~halt & ~dREN & ~dWEN`: `pc_en = 1`; stay in FETCH.
- With no `ihit`: `pc_en = 0`; stay in FETCH.
- `dhit` is ignored in FETCH.

**DATA**
- `imemREN = 0`, `dmemREN = rd_q`, `dmemWEN = wr_q`. Data access has priority over fetch.
- On `dhit`: `pc_en = 1`; next state is FETCH; clear `rd_q` and `wr_q`.
- Otherwise `pc_en = 0`; stay in DATA.
- `ihit` is ignored in DATA.

**HALT**
- All request outputs are 0, `pc_en = 0`, `halted = 1`.
- The block stays in HALT until `nRST` is asserted.

**Counters**
- `instr_count` increments on every cycle with `pc_en = 1`.
- `stall_count` increments on every non-HALT cycle with `pc_en = 0`.
- Both counters saturate at 2^CW−1; they do not wrap.
- Neither counter changes in HALT.

## Timing
**Reset**
- Reset is synchronous: while `nRST = 0`, every output is forced to 0 combinationally.
- At the clock edge with `nRST = 0`: `state` ← FETCH, `rd_q`/`wr_q` ← 0, both counters ← 0.
- The first cycle after `nRST` is deasserted is in FETCH.
- Reset asserted in DATA or HALT drops any outstanding request at that edge; there is no completion or write-back.

**Combinational vs registered outputs**
- `imemREN`, `dmemREN`, `dmemWEN` and `halted` are decoded only from `state`, `rd_q`, `wr_q` and `iREN`. There is no path from `ihit`/`dhit` to the request outputs.
- `pc_en` is combinational from `ihit`/`dhit`, so the PC advances on the edge that ends the hit cycle.

**Latency**
- Non-memory instruction: 1 cycle plus the `ihit` wait.
- Load/store: the `ihit` cycle, then at least 1 DATA cycle. `dmemREN`/`dmemWEN` rise on the cycle after `ihit`.

**Handshake**
- A request is held stable until its hit is seen.
- A hit in the same cycle as the request assertion is legal.
- `dmemREN` and `dmemWEN` are never asserted together.
- `imemREN` and the data requests are never asserted together.

## Test plan
- **Reset:** `nRST = 0` for 2 cycles with `iREN = 1`, `ihit = 1` → all outputs 0. After release, `imemREN = 1`; counters read 0.
- **ALU instructions:** 4 consecutive instructions, `ihit = 1` every cycle, `dREN = dWEN = 0` → `pc_en = 1` for 4 cycles, `instr_count = 4`, `stall_count = 0`.
- **Load with memory latency:**
  - `ihit` with `dREN = 1`, then `dhit` held low for 3 cycles before rising.
  - → `dmemREN = 1` for 4 cycles, `imemREN = 0` throughout.
  - → `pc_en = 1` only on the `dhit` cycle.
  - → `instr_count = 1`, `stall_count = 4`.
- **Simultaneous requests:** `ihit` with `dREN = dWEN = 1` and `dhit` the next cycle → `dmemWEN = 1`, `dmemREN = 0`. `ihit` with `halt = dWEN = 1` → HALT with no data request issued.
- **Halt behaviour:** after halt, apply `ihit`, `dhit` and `iREN` for 10 cycles → `halted = 1`, no requests, counters frozen. Then `nRST = 0` for one edge → `halted = 0`, back in FETCH.
- **Reset mid-operation and saturation:**
  - Assert reset during DATA → `dmemWEN` drops to 0 on that cycle; FETCH after release.
  - Build with `CW = 4` and run 20 ALU instructions → `instr_count` saturates at 15.

Source files
------------

// File: rtl/request_unit.sv
// request_unit: sequences instruction and data cache requests one at a time
// for the single-cycle datapath, generates the PC commit enable, the sticky
// halt indication and two saturating performance counters.
module request_unit #(
    parameter int CW = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iREN,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic          halt,
    input  logic          ihit,
    input  logic          dhit,
    output logic          imemREN,
    output logic          dmemREN,
    output logic          dmemWEN,
    output logic          pc_en,
    output logic          halted,
    output logic [CW-1:0] instr_count,
    output logic [CW-1:0] stall_count
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_q, state_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [CW-1:0] instr_q, instr_d;
    logic [CW-1:0] stall_q, stall_d;

    // Undecorated versions of the outputs, before the reset gating.
    logic imem_ren_c;
    logic dmem_ren_c;
    logic dmem_wen_c;
    logic pc_en_c;
    logic halted_c;

    // State, latched data request and counters; reset clears everything,
    // dropping any outstanding data request without completing it.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= FETCH;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            instr_q <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            instr_q <= instr_d;
            stall_q <= stall_d;
        end
    end

    // Next-state and output decode. Request outputs depend only on state,
    // the latched request and iREN; pc_en alone looks at the hit inputs.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        imem_ren_c = 1'b0;
        dmem_ren_c = 1'b0;
        dmem_wen_c = 1'b0;
        pc_en_c    = 1'b0;
        halted_c   = 1'b0;
        case (state_q)
            FETCH: begin
                imem_ren_c = iREN;
                if (ihit) begin
                    if (halt) begin
                        // Halt wins over a data request decoded alongside it.
                        state_d = HALT;
                    end else if (dREN || dWEN) begin
                        // A store wins if both requests are decoded.
                        state_d = DATA;
                        wr_d    = dWEN;
                        rd_d    = dREN & ~dWEN;
                    end else begin
                        pc_en_c = 1'b1;
                    end
                end
            end
            DATA: begin
                dmem_ren_c = rd_q;
                dmem_wen_c = wr_q;
                if (dhit) begin
                    pc_en_c = 1'b1;
                    state_d = FETCH;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = FETCH;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // Saturating counters; both hold still once halted.
    always_comb begin
        instr_d = instr_q;
        stall_d = stall_q;
        if (state_q != HALT) begin
            if (pc_en_c) begin
                if (instr_q != CNT_MAX) begin
                    instr_d = instr_q + CNT_ONE;
                end
            end else begin
                if (stall_q != CNT_MAX) begin
                    stall_d = stall_q + CNT_ONE;
                end
            end
        end
    end

    // Every output reads as zero while reset is held, before the edge acts.
    assign imemREN     = nRST & imem_ren_c;
    assign dmemREN     = nRST & dmem_ren_c;
    assign dmemWEN     = nRST & dmem_wen_c;
    assign pc_en       = nRST & pc_en_c;
    assign halted      = nRST & halted_c;
    assign instr_count = nRST ? instr_q : '0;
    assign stall_count = nRST ? stall_q : '0;

endmodule
